// File: rtl/luma_frame_gate.sv
// RGB-to-luma converter plus single-frame capture gate feeding the histogram stage.
// Latency: 2 cycles from r/g/b/dv/hs/vs to y/dv/hs/vs; frame_done_o aligns with vs_o rising.
// Backpressure: none; one pixel per cycle streams through and the consumer must accept it.
module luma_frame_gate #(
    parameter int CNT_W    = 22,
    parameter bit PASS_ALL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       r_i,
    input  logic [7:0]       g_i,
    input  logic [7:0]       b_i,
    input  logic             dv_i,
    input  logic             hs_i,
    input  logic             vs_i,
    input  logic             trigger_i,
    output logic [7:0]       y_o,
    output logic             dv_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] pixel_count_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_vs_prev;
    logic             w_sof;
    logic             w_eof;
    logic             w_pass;
    logic             w_cnt_clr;
    logic             w_done;

    // Stage 1: products and delayed controls
    logic [15:0]      r_prod_r;
    logic [15:0]      r_prod_g;
    logic [15:0]      r_prod_b;
    logic             r_dv_s1;
    logic             r_hs_s1;
    logic             r_vs_s1;
    logic             r_pass_s1;

    // Stage 2: rounded luma and aligned controls
    logic [15:0]      w_sum;
    logic [7:0]       w_sum_unused;
    logic [7:0]       r_y;
    logic             r_dv_s2;
    logic             r_hs_s2;
    logic             r_vs_s2;

    logic             r_busy;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pixel_count;

    // Frame edges relative to the previous cycle's vs; after reset the previous vs reads as 0.
    assign w_sof = ~vs_i & r_vs_prev;
    assign w_eof = vs_i & ~r_vs_prev;

    // Remember last cycle's vs for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_prev <= vs_i;
        end
    end

    // Capture state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, per-pixel pass decision and counter control
    always_comb begin
        w_state_nxt = r_state;
        w_pass      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Edges are irrelevant here; only a trigger arms the gate.
                if (trigger_i) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // The SOF cycle itself belongs to the captured frame.
                if (w_sof) begin
                    w_state_nxt = S_CAPTURE;
                    w_pass      = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_CAPTURE: begin
                // The EOF cycle is already blanking, so its dv is dropped.
                if (w_eof) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_pass = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_done      = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Captured-pixel counter: restarts at SOF (counting that cycle's pixel) and saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= {{(CNT_W-1){1'b0}}, dv_i};
        end else if (w_pass && dv_i && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Pipeline stage 1: weighted colour products and delayed controls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_r  <= '0;
            r_prod_g  <= '0;
            r_prod_b  <= '0;
            r_dv_s1   <= 1'b0;
            r_hs_s1   <= 1'b0;
            r_vs_s1   <= 1'b0;
            r_pass_s1 <= 1'b0;
        end else begin
            r_prod_r  <= 16'(r_i) * 16'd77;
            r_prod_g  <= 16'(g_i) * 16'd150;
            r_prod_b  <= 16'(b_i) * 16'd29;
            r_dv_s1   <= dv_i;
            r_hs_s1   <= hs_i;
            r_vs_s1   <= vs_i;
            r_pass_s1 <= w_pass;
        end
    end

    // Weights sum to 256, so the rounded sum peaks at 65408 and fits 16 bits.
    assign w_sum        = r_prod_r + r_prod_g + r_prod_b + 16'd128;
    assign w_sum_unused = w_sum[7:0];

    // Pipeline stage 2: luma and gated valid, aligned with delayed syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_dv_s2 <= 1'b0;
            r_hs_s2 <= 1'b0;
            r_vs_s2 <= 1'b0;
        end else begin
            r_y     <= w_sum[15:8];
            r_dv_s2 <= PASS_ALL ? r_dv_s1 : (r_dv_s1 & r_pass_s1);
            r_hs_s2 <= r_hs_s1;
            r_vs_s2 <= r_vs_s1;
        end
    end

    // Status: busy tracks the state being entered; DONE publishes the count and a pulse
    // that lands one cycle after DONE, i.e. together with vs_o rising.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_pixel_count <= '0;
        end else begin
            r_busy       <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
            r_frame_done <= w_done;
            if (w_done) begin
                r_pixel_count <= r_cnt;
            end
        end
    end

    assign y_o           = r_y;
    assign dv_o          = r_dv_s2;
    assign hs_o          = r_hs_s2;
    assign vs_o          = r_vs_s2;
    assign busy_o        = r_busy;
    assign frame_done_o  = r_frame_done;
    assign pixel_count_o = r_pixel_count;

endmodule

// File: tb/tb_luma_frame_gate.sv
// Bench for luma_frame_gate: gated and pass-all instances driven from the same stimulus.
// Latency: outputs compared every cycle, 1 time unit after the rising edge.
// Backpressure: none; the bench streams one input per clock.
module tb_luma_frame_gate;
    localparam int CNT_W = 22;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       r_i, g_i, b_i;
    logic             dv_i, hs_i, vs_i, trigger_i;

    logic [7:0]       y_o, y_pa;
    logic             dv_o, dv_pa, hs_o, hs_pa, vs_o, vs_pa;
    logic             busy_o, busy_pa, fd_o, fd_pa;
    logic [CNT_W-1:0] pc_o, pc_pa;

    always #5 clk = ~clk;

    luma_frame_gate #(.CNT_W(CNT_W), .PASS_ALL(1'b0)) dut (
        .clk(clk), .rst(rst), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i), .trigger_i(trigger_i),
        .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .busy_o(busy_o),
        .frame_done_o(fd_o), .pixel_count_o(pc_o)
    );

    luma_frame_gate #(.CNT_W(CNT_W), .PASS_ALL(1'b1)) dut_pa (
        .clk(clk), .rst(rst), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i), .trigger_i(trigger_i),
        .y_o(y_pa), .dv_o(dv_pa), .hs_o(hs_pa), .vs_o(vs_pa), .busy_o(busy_pa),
        .frame_done_o(fd_pa), .pixel_count_o(pc_pa)
    );

    int tests  = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: what entered the pipe one edge ago, plus capture bookkeeping.
    typedef struct packed {
        logic [7:0] r, g, b;
        logic       dv, hs, vs, pass;
    } in_t;

    in_t prev_in;
    bit  m_prev_vs, m_armed, m_capt, m_finish;
    int  m_cnt, m_pc;
    int  dvo_cnt, dvpa_cnt, fd_cnt;
    bit  last_vs_o;

    function automatic int luma(input in_t s);
        return (77 * int'(s.r) + 150 * int'(s.g) + 29 * int'(s.b) + 128) / 256;
    endfunction

    task automatic clear_stats();
        dvo_cnt  = 0;
        dvpa_cnt = 0;
        fd_cnt   = 0;
    endtask

    task automatic tick(input logic trig, input logic rs);
        int  e_y, e_dv, e_dvpa, e_hs, e_vs, e_busy, e_fd;
        bit  sof, eof, pass;
        trigger_i = trig;
        rst       = rs;
        @(posedge clk);
        e_y = 0; e_dv = 0; e_dvpa = 0; e_hs = 0; e_vs = 0; e_fd = 0;
        if (rs) begin
            prev_in   = '0;
            m_prev_vs = 1'b0;
            m_armed   = 1'b0;
            m_capt    = 1'b0;
            m_finish  = 1'b0;
            m_cnt     = 0;
            m_pc      = 0;
        end else begin
            e_y    = luma(prev_in);
            e_dv   = int'(prev_in.dv & prev_in.pass);
            e_dvpa = int'(prev_in.dv);
            e_hs   = int'(prev_in.hs);
            e_vs   = int'(prev_in.vs);
            sof    = !vs_i && m_prev_vs;
            eof    = vs_i && !m_prev_vs;
            pass   = 1'b0;
            if (m_finish) begin
                // cycle after the frame ended: publish, ignore any trigger
                e_fd     = 1;
                m_pc     = m_cnt;
                m_finish = 1'b0;
            end else if (m_capt) begin
                if (eof) begin
                    m_capt   = 1'b0;
                    m_finish = 1'b1;
                end else begin
                    pass = 1'b1;
                end
            end else if (m_armed) begin
                if (sof) begin
                    m_armed = 1'b0;
                    m_capt  = 1'b1;
                    m_cnt   = 0;
                    pass    = 1'b1;
                end
            end else if (trig) begin
                m_armed = 1'b1;
            end
            if (pass && dv_i && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            prev_in   = '{r: r_i, g: g_i, b: b_i, dv: dv_i, hs: hs_i, vs: vs_i, pass: pass};
            m_prev_vs = vs_i;
        end
        e_busy = int'(m_armed || m_capt);
        #1;
        chk("y_o", int'(y_o), e_y);
        chk("dv_o", int'(dv_o), e_dv);
        chk("hs_o", int'(hs_o), e_hs);
        chk("vs_o", int'(vs_o), e_vs);
        chk("busy_o", int'(busy_o), e_busy);
        chk("frame_done_o", int'(fd_o), e_fd);
        chk("pixel_count_o", int'(pc_o), m_pc);
        chk("pa_y_o", int'(y_pa), e_y);
        chk("pa_dv_o", int'(dv_pa), e_dvpa);
        chk("pa_hs_o", int'(hs_pa), e_hs);
        chk("pa_vs_o", int'(vs_pa), e_vs);
        chk("pa_busy_o", int'(busy_pa), e_busy);
        chk("pa_frame_done_o", int'(fd_pa), e_fd);
        chk("pa_pixel_count_o", int'(pc_pa), m_pc);
        if (dv_o) dvo_cnt++;
        if (dv_pa) dvpa_cnt++;
        if (fd_o) begin
            fd_cnt++;
            chk("done_on_vs_rise", int'({vs_o, last_vs_o}), 2);
        end
        last_vs_o = vs_o;
    endtask

    task automatic set_pix(input logic dv, input logic hs, input logic vs);
        r_i  = 8'($urandom_range(0, 255));
        g_i  = 8'($urandom_range(0, 255));
        b_i  = 8'($urandom_range(0, 255));
        dv_i = dv;
        hs_i = hs;
        vs_i = vs;
    endtask

    task automatic blank_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_pix(1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b0);
        end
    endtask

    // Vertical blank, then h lines of w pixels each followed by two hblank cycles.
    task automatic frame(input int w, input int h, input int blank,
                         input int trig_at, input int rst_at, input bit rnd);
        int idx;
        idx = 0;
        for (int b = 0; b < blank; b++) begin
            set_pix(1'b0, 1'b0, 1'b1);
            tick(idx == trig_at, idx == rst_at);
            idx++;
        end
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) begin
                set_pix(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
                tick(idx == trig_at, idx == rst_at);
                idx++;
            end
            for (int c = 0; c < 2; c++) begin
                set_pix(1'b0, c == 0, 1'b0);
                tick(idx == trig_at, idx == rst_at);
                idx++;
            end
        end
    endtask

    typedef struct {
        logic [7:0] r, g, b;
        int         y;
    } luma_vec_t;

    luma_vec_t lv[8];
    int        saved;

    initial begin
        lv[0] = '{r: 8'd255, g: 8'd255, b: 8'd255, y: 255};
        lv[1] = '{r: 8'd255, g: 8'd0,   b: 8'd0,   y: 77};
        lv[2] = '{r: 8'd0,   g: 8'd0,   b: 8'd255, y: 29};
        lv[3] = '{r: 8'd0,   g: 8'd0,   b: 8'd0,   y: 0};
        lv[4] = '{r: 8'd0,   g: 8'd255, b: 8'd0,   y: 149};
        lv[5] = '{r: 8'd128, g: 8'd128, b: 8'd128, y: 128};
        lv[6] = '{r: 8'd10,  g: 8'd20,  b: 8'd30,  y: 18};
        lv[7] = '{r: 8'd1,   g: 8'd1,   b: 8'd1,   y: 1};

        r_i = '0; g_i = '0; b_i = '0;
        dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; trigger_i = 1'b0; rst = 1'b1;
        last_vs_o = 1'b0;
        prev_in = '0;
        m_prev_vs = 1'b0; m_armed = 1'b0; m_capt = 1'b0; m_finish = 1'b0;
        m_cnt = 0; m_pc = 0;
        clear_stats();

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        chk("rst_y", int'(y_o), 0);
        chk("rst_dv", int'(dv_o), 0);
        chk("rst_vs", int'(vs_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(fd_o), 0);
        chk("rst_count", int'(pc_o), 0);

        // Luma vectors with continuous dv: each held two cycles, then read back
        for (int i = 0; i < 8; i++) begin
            r_i = lv[i].r; g_i = lv[i].g; b_i = lv[i].b;
            dv_i = 1'b1; hs_i = 1'b0; vs_i = 1'b0;
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            chk($sformatf("luma_vec%0d", i), int'(y_o), lv[i].y);
        end

        // 4x3 frame, trigger mid-blanking
        clear_stats();
        frame(4, 3, 5, 2, -1, 1'b0);
        blank_cycles(6);
        chk("cap_dv_pulses", dvo_cnt, 12);
        chk("cap_done_pulses", fd_cnt, 1);
        chk("cap_count", int'(pc_o), 12);
        chk("cap_busy_end", int'(busy_o), 0);

        // Trigger mid-frame: that frame is skipped, the next is captured
        clear_stats();
        frame(4, 3, 5, 8, -1, 1'b0);
        chk("midtrig_skip", dvo_cnt, 0);
        frame(4, 3, 5, -1, -1, 1'b0);
        blank_cycles(6);
        chk("midtrig_dv_pulses", dvo_cnt, 12);
        chk("midtrig_done", fd_cnt, 1);
        chk("midtrig_count", int'(pc_o), 12);

        // Trigger on the SOF cycle, then a second trigger during capture
        clear_stats();
        frame(4, 3, 5, 5, -1, 1'b0);
        chk("softrig_skip", dvo_cnt, 0);
        frame(4, 3, 5, 8, -1, 1'b0);
        blank_cycles(6);
        chk("softrig_dv_pulses", dvo_cnt, 12);
        chk("softrig_done", fd_cnt, 1);
        chk("softrig_busy_end", int'(busy_o), 0);

        // Reset after 5 captured pixels, then an untriggered frame
        clear_stats();
        frame(4, 3, 5, 1, 12, 1'b0);
        saved = dvo_cnt;
        frame(4, 3, 5, -1, -1, 1'b0);
        blank_cycles(6);
        chk("rstcap_no_dv_after", dvo_cnt, saved);
        chk("rstcap_no_done", fd_cnt, 0);
        chk("rstcap_count", int'(pc_o), 0);
        chk("rstcap_busy", int'(busy_o), 0);

        // Pass-all instance follows dv with no trigger; no completion pulse
        clear_stats();
        frame(4, 3, 5, -1, -1, 1'b0);
        blank_cycles(6);
        chk("passall_dv_pulses", dvpa_cnt, 12);
        chk("passall_gated_dv", dvo_cnt, 0);
        chk("passall_no_done", int'(fd_cnt), 0);

        // Randomized frames: random sizes, dv, trigger placement and occasional reset
        for (int f = 0; f < 40; f++) begin
            int w, h, bl, len, tr, ra;
            w   = $urandom_range(1, 6);
            h   = $urandom_range(1, 4);
            bl  = $urandom_range(2, 6);
            len = bl + h * (w + 2);
            tr  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, len - 1));
            ra  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            frame(w, h, bl, tr, ra, 1'b1);
        end
        blank_cycles(6);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/luma_frame_gate.md
Name: luma_frame_gate

Overview:
- Upstream neighbour of the histogram stage, in the rx_clk video domain.
- Converts 24-bit RGB video from the receiver to 8-bit luma (BT.601 integer approximation) in a 2-stage pipeline, with sync signals delay-matched.
- On a CPU trigger, gates exactly one complete frame of data-valid through to the histogram stage, then reports completion and the captured pixel count.

Parameters:
- CNT_W, 22, width of the captured-pixel counter; 22 covers 1920x1080.
- PASS_ALL, 0, when 1 dv_o follows the delayed dv with no gating; the FSM still runs.

Ports:
- clk  input  1  pixel clock (rx_clk domain)
- rst  input  1  synchronous reset, active-high
- r_i  input  8  red component
- g_i  input  8  green component
- b_i  input  8  blue component
- dv_i  input  1  pixel valid
- hs_i  input  1  horizontal sync, passed through only
- vs_i  input  1  vertical sync; high = vertical blanking
- trigger_i  input  1  one-cycle capture request from CPU
- y_o  output  8  luma
- dv_o  output  1  gated pixel valid, aligned to y_o
- hs_o  output  1  hs_i delayed 2 cycles
- vs_o  output  1  vs_i delayed 2 cycles
- busy_o  output  1  high in ARMED or CAPTURE
- frame_done_o  output  1  one-cycle pulse at end of a captured frame
- pixel_count_o  output  CNT_W  pixels passed in the last captured frame

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset mid-operation aborts any capture; no frame_done pulse; a new trigger is required.
- Luma: Y = (77*R + 150*G + 29*B + 128) >> 8.
  - Unsigned arithmetic, 16-bit sum, no overflow (max 65408 → 255), no saturation needed.
  - Stage 1 registers the three products. Stage 2 registers the rounded sum shifted right by 8.
- Latency: exactly 2 cycles from r/g/b/dv/hs/vs at the input to y/dv/hs/vs at the output.
- Frame boundaries are taken from vs_i against its value on the previous cycle:
  - Frame start (SOF): vs_i=0 while the previous cycle was 1.
  - Frame end (EOF): vs_i=1 while the previous cycle was 0.
  - The first cycle after reset treats the previous vs as 0.
- FSM:
  - IDLE: trigger_i=1 → ARMED. vs edges are ignored.
  - ARMED: SOF → CAPTURE. A trigger in the same cycle as an SOF does not capture that frame; capture waits for the following SOF.
  - CAPTURE: every input cycle with dv_i=1 is marked for pass, including the SOF cycle. On EOF → DONE; the EOF cycle's dv_i is not passed.
  - DONE: lasts 1 cycle, then IDLE. In that cycle pixel_count_o is loaded from the counter, and frame_done_o rises 2 cycles after the EOF input cycle so it aligns with vs_o rising.
- Triggers received in ARMED, CAPTURE or DONE are ignored; triggers are not queued.
- Pass flag: computed at the input stage and pipelined with the data. dv_o = delayed dv & delayed pass when PASS_ALL=0; dv_o = delayed dv when PASS_ALL=1.
- Counter:
  - Cleared on SOF entering CAPTURE.
  - Incremented per passed pixel.
  - Saturates at 2^CNT_W-1.
- pixel_count_o holds its value until the next DONE.
- busy_o is registered from state and is high during ARMED and CAPTURE.
- hs is not interpreted; it is only delayed.

Test Plan:
- R=G=B=255, dv=1 continuous → y_o=255 two cycles later. R=255,G=0,B=0 → y_o=77. R=0,G=0,B=255 → y_o=29. All zeros → y_o=0.
- 4x3 frame (vs high 5 cycles, 3 lines of 4 dv pulses, vs high again), trigger mid-blanking → dv_o has exactly 12 pulses, frame_done_o pulses once coincident with vs_o rising, pixel_count_o=12, busy_o returns 0.
- Trigger mid-frame → that frame produces no dv_o. The next full frame is passed with count=12, and the partial frame is not counted.
- Trigger in the same cycle as the vs falling edge → no capture that frame, capture of the next frame. A second trigger during CAPTURE → no effect, one frame_done only.
- Assert rst during CAPTURE after 5 pixels → all outputs 0 next cycle and no frame_done. A following frame without a trigger yields dv_o=0 throughout.
- PASS_ALL=1, no trigger → dv_o equals dv_i delayed 2 for all frames, and frame_done_o stays 0.
